// File: rtl/xt_macro_seq_pkg.sv
// xt_macro_seq_pkg: instruction field layout, macro/uop encodings, sequence lengths and FSM states.
package xt_macro_seq_pkg;
  localparam int HBIT_ADDR = 14;
  localparam int HBIT_DATA = 31;
  localparam int SET_HI = 31, SET_LO = 29, OPC_HI = 28, OPC_LO = 23;
  localparam int RA_HI = 22, RA_LO = 19, RB_HI = 18, RB_LO = 15, IMM_HI = 14, IMM_LO = 0;
  typedef logic [HBIT_ADDR:0] addr_t;
  typedef logic [HBIT_DATA:0] data_t;
  typedef logic [2:0] iset_t;
  typedef logic [5:0] opc_t;
  typedef logic [3:0] reg_t;
  localparam iset_t INSTRSET_RU = 3'd0, INSTRSET_RS = 3'd1, INSTRSET_IU = 3'd2;
  localparam iset_t INSTRSET_IS = 3'd3, INSTRSET_SR = 3'd4, INSTRSET_ISA = 3'd7;
  localparam opc_t OPC_PUSH = 6'd0, OPC_POP = 6'd1, OPC_JSR = 6'd2, OPC_JSRI = 6'd3;
  localparam opc_t OPC_BSR = 6'd4, OPC_BSRI = 6'd5, OPC_RET = 6'd6;
  // Register-target jumps/branches use the RU set, immediate targets the SR set.
  localparam opc_t UOPC_ADD = 6'h01, UOPC_SUB = 6'h02, UOPC_LD = 6'h10, UOPC_ST = 6'h11;
  localparam opc_t UOPC_JMP = 6'h20, UOPC_BRA = 6'h21, UOPC_TRAP = 6'h3E;
  localparam logic [2:0] SEQLEN_PUSH = 3'd2, SEQLEN_POP = 3'd2, SEQLEN_JSR = 3'd3;
  localparam logic [2:0] SEQLEN_BSR = 3'd3, SEQLEN_RET = 3'd3;
  localparam data_t UOP_TRAP_ILLEGAL = {INSTRSET_SR, UOPC_TRAP, 4'd0, 4'd0, 15'd0};
  typedef enum logic {ST_IDLE, ST_EXPAND} state_t;
  function automatic data_t mk_uop(iset_t s, opc_t o, reg_t a, reg_t b, addr_t m);
    return {s, o, a, b, m};
  endfunction
endpackage

// File: rtl/xt_macro_seq_if.sv
// xt_macro_seq_if: fetch-side inputs and decode-side outputs of the macro sequencer.
interface xt_macro_seq_if;
  import xt_macro_seq_pkg::*;
  addr_t iw_pc;
  data_t iw_instr;
  logic iw_flush;
  logic iw_stall;
  addr_t ow_pc;
  data_t ow_instr;
  logic ow_stall_up;
  logic ow_busy;
  modport master(output iw_pc, iw_instr, iw_flush, iw_stall, input ow_pc, ow_instr, ow_stall_up, ow_busy);
  modport slave(input iw_pc, iw_instr, iw_flush, iw_stall, output ow_pc, ow_instr, ow_stall_up, ow_busy);
endinterface

// File: rtl/xt_macro_seq_uop_rom.sv
// xt_uop_rom: combinational macro -> micro-op table; unknown opcodes give NOP,
// or UOP_TRAP_ILLEGAL when XT_SEQ_ILLEGAL_TRAP_EN is defined.
module xt_uop_rom
  import xt_macro_seq_pkg::*;
#(
  parameter int SP_REG = 15,
  parameter int LR_REG = 14,
  parameter int STEP_W = 2
) (
  input  opc_t              opc,
  input  reg_t              ra,
  input  reg_t              rb,
  input  addr_t             imm,
  input  logic [STEP_W-1:0] step,
  input  addr_t             pc,
  output data_t             uop,
  output logic [2:0]        len
);
  localparam reg_t SP = reg_t'(SP_REG);
  localparam reg_t LR = reg_t'(LR_REG);
`ifdef XT_SEQ_ILLEGAL_TRAP_EN
  localparam data_t UNKNOWN_UOP = UOP_TRAP_ILLEGAL;
`else
  localparam data_t UNKNOWN_UOP = '0;
`endif
  logic s0, s1;
  data_t sub_sp, add_sp, st_rs, st_ret, ld_rd, ld_lr, jmp_imm, jmp_rb, jmp_lr, bra_imm, bra_rb;
  assign s0 = step == '0;
  assign s1 = step == STEP_W'(1);
  assign sub_sp = mk_uop(INSTRSET_IU, UOPC_SUB, SP, SP, 15'd1);
  assign add_sp = mk_uop(INSTRSET_IU, UOPC_ADD, SP, SP, 15'd1);
  assign st_rs = mk_uop(INSTRSET_RS, UOPC_ST, ra, SP, '0);
  assign st_ret = mk_uop(INSTRSET_IS, UOPC_ST, 4'd0, SP, pc + addr_t'(1));
  assign ld_rd = mk_uop(INSTRSET_RS, UOPC_LD, ra, SP, '0);
  assign ld_lr = mk_uop(INSTRSET_RS, UOPC_LD, LR, SP, '0);
  assign jmp_imm = mk_uop(INSTRSET_SR, UOPC_JMP, 4'd0, 4'd0, imm);
  assign jmp_rb = mk_uop(INSTRSET_RU, UOPC_JMP, 4'd0, rb, '0);
  assign jmp_lr = mk_uop(INSTRSET_RU, UOPC_JMP, 4'd0, LR, '0);
  assign bra_imm = mk_uop(INSTRSET_SR, UOPC_BRA, 4'd0, 4'd0, imm);
  assign bra_rb = mk_uop(INSTRSET_RU, UOPC_BRA, 4'd0, rb, '0);
  always_comb begin
    len = 3'd1;
    uop = UNKNOWN_UOP;
    case (opc)
      OPC_PUSH: begin len = SEQLEN_PUSH; uop = s0 ? sub_sp : st_rs; end
      OPC_POP: begin len = SEQLEN_POP; uop = s0 ? ld_rd : add_sp; end
      OPC_JSR, OPC_JSRI: begin
        len = SEQLEN_JSR;
        uop = s0 ? sub_sp : s1 ? st_ret : (opc == OPC_JSR ? jmp_imm : jmp_rb);
      end
      OPC_BSR, OPC_BSRI: begin
        len = SEQLEN_BSR;
        uop = s0 ? sub_sp : s1 ? st_ret : (opc == OPC_BSR ? bra_imm : bra_rb);
      end
      OPC_RET: begin len = SEQLEN_RET; uop = s0 ? ld_lr : s1 ? add_sp : jmp_lr; end
      default: ;
    endcase
  end
endmodule

// File: rtl/xt_macro_seq.sv
// xt_macro_seq: translate-stage sequencer expanding ISA macros into micro-op sequences;
// unknown-opcode handling selected by XT_SEQ_ILLEGAL_TRAP_EN (see xt_uop_rom).
module xt_macro_seq
  import xt_macro_seq_pkg::*;
#(
  parameter int SP_REG = 15,
  parameter int LR_REG = 14,
  parameter int STEP_W = 2
) (
  input logic         iw_clk,
  input logic         iw_rst,
  xt_macro_seq_if.slave sif
);
  state_t state;
  logic [STEP_W-1:0] step;
  data_t mac, cur, uop;
  addr_t mac_pc, cur_pc;
  logic [2:0] len;
  logic idle;
  assign idle = state == ST_IDLE;
  // In IDLE the fetch word is decoded directly, so uop0 leaves on the capture edge.
  assign cur = idle ? sif.iw_instr : mac;
  assign cur_pc = idle ? sif.iw_pc : mac_pc;
  assign sif.ow_stall_up = sif.iw_stall | !idle;
  assign sif.ow_busy = !idle;
  xt_uop_rom #(.SP_REG(SP_REG), .LR_REG(LR_REG), .STEP_W(STEP_W)) u_rom (
    .opc (cur[OPC_HI:OPC_LO]),
    .ra  (cur[RA_HI:RA_LO]),
    .rb  (cur[RB_HI:RB_LO]),
    .imm (cur[IMM_HI:IMM_LO]),
    .step(step),
    .pc  (cur_pc),
    .uop (uop),
    .len (len)
  );
  always_ff @(posedge iw_clk or posedge iw_rst)
    if (iw_rst) begin
      state <= ST_IDLE;
      step <= '0;
      mac <= '0;
      mac_pc <= '0;
      sif.ow_pc <= '0;
      sif.ow_instr <= '0;
    end else if (sif.iw_flush) begin
      state <= ST_IDLE;
      step <= '0;
      sif.ow_pc <= '0;
      sif.ow_instr <= '0;
    end else if (!sif.iw_stall) begin
      sif.ow_pc <= cur_pc;
      if (idle && cur[SET_HI:SET_LO] != INSTRSET_ISA) sif.ow_instr <= cur;
      else begin
        sif.ow_instr <= uop;
        if (idle) begin
          mac <= cur;
          mac_pc <= cur_pc;
        end
        if (3'(step) == len - 3'd1) begin
          state <= ST_IDLE;
          step <= '0;
        end else begin
          state <= ST_EXPAND;
          step <= step + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_xt_macro_seq.sv
// tb_xt_macro_seq: directed scenarios plus random stream checked against a queue-based expansion model.
module tb_xt_macro_seq;
  import xt_macro_seq_pkg::*;
  logic iw_clk = 0, iw_rst = 1;
  int checks = 0, failures = 0;
  logic [46:0] pend[$];
  logic [46:0] expv = '0;
  xt_macro_seq_if sif ();
  xt_macro_seq dut (.iw_clk(iw_clk), .iw_rst(iw_rst), .sif(sif));
  always #5 iw_clk = ~iw_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic data_t w(input iset_t s, input opc_t o, input reg_t a, input reg_t b, input addr_t m);
    return {s, o, a, b, m};
  endfunction

  function automatic void expand(input data_t i, input addr_t pc);
    reg_t ra = i[22:19];
    reg_t rb = i[18:15];
    addr_t im = i[14:0];
    addr_t nx = pc + 15'd1;
    data_t dec = w(INSTRSET_IU, UOPC_SUB, 4'd15, 4'd15, 15'd1);
    data_t inc = w(INSTRSET_IU, UOPC_ADD, 4'd15, 4'd15, 15'd1);
    data_t push_ret = w(INSTRSET_IS, UOPC_ST, 4'd0, 4'd15, nx);
    data_t seq[$];
    if (i[31:29] != 3'd7) seq = '{i};
    else case (i[28:23])
      6'd0: seq = '{dec, w(INSTRSET_RS, UOPC_ST, ra, 4'd15, 15'd0)};
      6'd1: seq = '{w(INSTRSET_RS, UOPC_LD, ra, 4'd15, 15'd0), inc};
      6'd2: seq = '{dec, push_ret, w(INSTRSET_SR, UOPC_JMP, 4'd0, 4'd0, im)};
      6'd3: seq = '{dec, push_ret, w(INSTRSET_RU, UOPC_JMP, 4'd0, rb, 15'd0)};
      6'd4: seq = '{dec, push_ret, w(INSTRSET_SR, UOPC_BRA, 4'd0, 4'd0, im)};
      6'd5: seq = '{dec, push_ret, w(INSTRSET_RU, UOPC_BRA, 4'd0, rb, 15'd0)};
      6'd6: seq = '{w(INSTRSET_RS, UOPC_LD, 4'd14, 4'd15, 15'd0), inc, w(INSTRSET_RU, UOPC_JMP, 4'd0, 4'd14, 15'd0)};
`ifdef XT_SEQ_ILLEGAL_TRAP_EN
      default: seq = '{w(INSTRSET_SR, 6'h3E, 4'd0, 4'd0, 15'd0)};
`else
      default: seq = '{32'd0};
`endif
    endcase
    foreach (seq[k]) pend.push_back({pc, seq[k]});
  endfunction

  task automatic cyc(input data_t ins, input addr_t pc, input logic st, input logic fl);
    sif.iw_instr = ins;
    sif.iw_pc = pc;
    sif.iw_stall = st;
    sif.iw_flush = fl;
    #1;
    chk("stall_up", 64'(sif.ow_stall_up), 64'(st | (pend.size() != 0)));
    if (fl) begin
      pend.delete();
      expv = '0;
    end else if (!st) begin
      if (pend.size() == 0) expand(ins, pc);
      expv = pend.pop_front();
    end
    @(posedge iw_clk);
    #1;
    chk("pc", 64'(sif.ow_pc), 64'(expv[46:32]));
    chk("instr", 64'(sif.ow_instr), 64'(expv[31:0]));
    chk("busy", 64'(sif.ow_busy), 64'(pend.size() != 0));
  endtask

  function automatic data_t isa(input opc_t o, input reg_t a, input reg_t b, input addr_t m);
    return {3'd7, o, a, b, m};
  endfunction

  function automatic data_t rnd_instr();
    int r = $urandom_range(0, 11);
    data_t x = $urandom;
    if (r <= 6) return isa(opc_t'(r), x[22:19], x[18:15], x[14:0]);
    if (r == 7) return isa(6'h3F, x[22:19], x[18:15], x[14:0]);
    if (r == 8) return isa(opc_t'($urandom_range(7, 62)), x[22:19], x[18:15], x[14:0]);
    return {iset_t'($urandom_range(0, 4)), x[28:0]};
  endfunction

  initial begin
    sif.iw_pc = '0;
    sif.iw_instr = '0;
    sif.iw_flush = 0;
    sif.iw_stall = 0;
    repeat (2) @(posedge iw_clk);
    #1;
    chk("rst_pc", 64'(sif.ow_pc), 64'd0);
    chk("rst_instr", 64'(sif.ow_instr), 64'd0);
    chk("rst_busy", 64'(sif.ow_busy), 64'd0);
    chk("rst_stall_up", 64'(sif.ow_stall_up), 64'd0);
    iw_rst = 0;
    cyc({INSTRSET_RU, 6'h01, 4'd1, 4'd2, 15'd0}, 15'h10, 0, 0);
    cyc(isa(OPC_PUSH, 4'd3, 4'd0, 15'd0), 15'h20, 0, 0);
    chk("push_sub", 64'(sif.ow_instr), 64'({3'd2, 6'h02, 4'd15, 4'd15, 15'd1}));
    cyc(isa(OPC_PUSH, 4'd3, 4'd0, 15'd0), 15'h20, 0, 0);
    chk("push_st", 64'(sif.ow_instr), 64'({3'd1, 6'h11, 4'd3, 4'd15, 15'd0}));
    cyc(isa(OPC_JSR, 4'd0, 4'd0, 15'h400), 15'h30, 0, 0);
    cyc(isa(OPC_JSR, 4'd0, 4'd0, 15'h400), 15'h30, 0, 0);
    chk("jsr_st", 64'(sif.ow_instr), 64'({3'd3, 6'h11, 4'd0, 4'd15, 15'h31}));
    cyc(isa(OPC_JSR, 4'd0, 4'd0, 15'h400), 15'h30, 0, 0);
    chk("jsr_jmp", 64'(sif.ow_instr), 64'({3'd4, 6'h20, 4'd0, 4'd0, 15'h400}));
    cyc(isa(OPC_RET, 4'd0, 4'd0, 15'd0), 15'h40, 0, 0);
    cyc(isa(OPC_RET, 4'd0, 4'd0, 15'd0), 15'h40, 1, 0);
    cyc(isa(OPC_RET, 4'd0, 4'd0, 15'd0), 15'h40, 1, 0);
    cyc(isa(OPC_RET, 4'd0, 4'd0, 15'd0), 15'h40, 0, 0);
    cyc(isa(OPC_RET, 4'd0, 4'd0, 15'd0), 15'h40, 0, 0);
    cyc(isa(OPC_BSR, 4'd0, 4'd0, 15'h7FF0), 15'h7FFF, 0, 0);
    cyc(isa(OPC_BSR, 4'd0, 4'd0, 15'h7FF0), 15'h7FFF, 0, 1);
    cyc({INSTRSET_IU, 6'h05, 4'd2, 4'd3, 15'h55}, 15'h50, 0, 0);
    cyc(isa(6'h3F, 4'd0, 4'd0, 15'd0), 15'h60, 0, 0);
    cyc(isa(OPC_JSR, 4'd0, 4'd0, 15'h123), 15'h70, 0, 0);
    iw_rst = 1;
    #1;
    chk("arst_pc", 64'(sif.ow_pc), 64'd0);
    chk("arst_instr", 64'(sif.ow_instr), 64'd0);
    chk("arst_busy", 64'(sif.ow_busy), 64'd0);
    pend.delete();
    expv = '0;
    @(posedge iw_clk);
    #1;
    iw_rst = 0;
    for (int n = 0; n < 800; n++)
      cyc(rnd_instr(), addr_t'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
